// File: rtl/mem_lsu_if.sv
// Data-bus request/acknowledge channel between the memory stage and the data memory.
interface mem_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_lsu.sv
// MIPS memory-access stage: big-endian byte-lane bus transactions for loads/stores,
// HI/LO forwarding to EX, and the registered MEM/WB boundary.
module mem_lsu (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       wd_i,
    input  logic             wreg_i,
    input  logic [31:0]      wdata_i,
    input  logic [31:0]      hi_i,
    input  logic [31:0]      lo_i,
    input  logic             whilo_i,
    input  logic [7:0]       aluop_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      reg2_i,
    output logic [31:0]      mem_hi_o,
    output logic [31:0]      mem_lo_o,
    output logic             mem_whilo_o,
    output logic             stallreq_o,
    mem_lsu_if.master        bus,
    output logic [4:0]       wb_wd_o,
    output logic             wb_wreg_o,
    output logic [31:0]      wb_wdata_o,
    output logic [31:0]      wb_hi_o,
    output logic [31:0]      wb_lo_o,
    output logic             wb_whilo_o,
    output logic             exc_misalign_o
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t      r_state;
    logic        r_bus_req, r_bus_we;
    logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
    logic [3:0]  r_bus_sel;
    logic [4:0]  r_wb_wd;
    logic        r_wb_wreg, r_wb_whilo, r_exc;
    logic [31:0] r_wb_wdata, r_wb_hi, r_wb_lo;

    logic        w_is_byte, w_is_half, w_is_word, w_is_store, w_is_signed;
    logic        w_is_mem, w_misalign;
    logic [1:0]  w_lane;
    logic [3:0]  w_sel;
    logic [31:0] w_store_data, w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_is_byte   = 1'b0;
        w_is_half   = 1'b0;
        w_is_word   = 1'b0;
        w_is_store  = 1'b0;
        w_is_signed = 1'b0;
        case (aluop_i)
            EXE_LB_OP:  begin w_is_byte = 1'b1; w_is_signed = 1'b1; end
            EXE_LBU_OP: w_is_byte = 1'b1;
            EXE_LH_OP:  begin w_is_half = 1'b1; w_is_signed = 1'b1; end
            EXE_LHU_OP: w_is_half = 1'b1;
            EXE_LW_OP:  w_is_word = 1'b1;
            EXE_SB_OP:  begin w_is_byte = 1'b1; w_is_store = 1'b1; end
            EXE_SH_OP:  begin w_is_half = 1'b1; w_is_store = 1'b1; end
            EXE_SW_OP:  begin w_is_word = 1'b1; w_is_store = 1'b1; end
            default:    ;
        endcase
    end

    assign w_lane     = mem_addr_i[1:0];
    assign w_is_mem   = w_is_byte | w_is_half | w_is_word;
    assign w_misalign = (w_is_half & w_lane[0]) | (w_is_word & (w_lane != 2'b00));

    // Lane 0 is the most significant byte; store data is replicated so any lane can pick it up.
    always_comb begin
        w_sel        = 4'b1111;
        w_store_data = reg2_i;
        if (w_is_byte) begin
            w_sel        = 4'b1000 >> w_lane;
            w_store_data = {4{reg2_i[7:0]}};
        end else if (w_is_half) begin
            w_sel        = w_lane[1] ? 4'b0011 : 4'b1100;
            w_store_data = {2{reg2_i[15:0]}};
        end
    end

    always_comb begin
        case (w_lane)
            2'd0:    w_byte = r_rdata[31:24];
            2'd1:    w_byte = r_rdata[23:16];
            2'd2:    w_byte = r_rdata[15:8];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = w_lane[1] ? r_rdata[15:0] : r_rdata[31:16];
        if (w_is_byte)
            w_load_data = {{24{w_is_signed & w_byte[7]}}, w_byte};
        else if (w_is_half)
            w_load_data = {{16{w_is_signed & w_half[15]}}, w_half};
        else
            w_load_data = r_rdata;
    end

    assign stallreq_o  = (r_state == S_BUS) | ((r_state == S_IDLE) & w_is_mem & ~w_misalign);
    assign mem_hi_o    = hi_i;
    assign mem_lo_o    = lo_i;
    assign mem_whilo_o = whilo_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_wb_wd     <= '0;
            r_wb_wreg   <= 1'b0;
            r_wb_wdata  <= '0;
            r_wb_hi     <= '0;
            r_wb_lo     <= '0;
            r_wb_whilo  <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            r_exc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem && !w_misalign) begin
                        r_state     <= S_BUS;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_bus_sel   <= w_sel;
                        r_bus_wdata <= w_store_data;
                        r_wb_wd     <= '0;
                        r_wb_wreg   <= 1'b0;
                        r_wb_wdata  <= '0;
                        r_wb_hi     <= '0;
                        r_wb_lo     <= '0;
                        r_wb_whilo  <= 1'b0;
                    end else begin
                        r_wb_wd    <= wd_i;
                        r_wb_wreg  <= wreg_i & ~w_misalign;
                        r_wb_wdata <= wdata_i;
                        r_wb_hi    <= hi_i;
                        r_wb_lo    <= lo_i;
                        r_wb_whilo <= whilo_i & ~w_misalign;
                        r_exc      <= w_misalign;
                    end
                end
                S_BUS: begin
                    if (bus.bus_ack) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_rdata   <= bus.bus_rdata;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_wb_wd    <= wd_i;
                    r_wb_wreg  <= wreg_i & ~w_is_store;
                    r_wb_wdata <= w_load_data;
                    r_wb_hi    <= hi_i;
                    r_wb_lo    <= lo_i;
                    r_wb_whilo <= whilo_i;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_wdata = r_bus_wdata;

    assign wb_wd_o        = r_wb_wd;
    assign wb_wreg_o      = r_wb_wreg;
    assign wb_wdata_o     = r_wb_wdata;
    assign wb_hi_o        = r_wb_hi;
    assign wb_lo_o        = r_wb_lo;
    assign wb_whilo_o     = r_wb_whilo;
    assign exc_misalign_o = r_exc;
endmodule
